// File: rtl/fir_stream_filter_if.sv
// Sample stream bundle for fir_stream_filter: sample input with ready, result output with strobe.
// master drives samples (ADC side / bench), slave is the filter.
interface fir_stream_filter_if #(
    parameter int DATA_W = 8
) ();
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/fir_stream_filter.sv
// Serial single-multiplier FIR on an offset-binary sample stream, with bypass and programmable taps.
// Optional FIR_ROUND_EN: round half up before the output shift (otherwise truncate toward -inf).
module fir_stream_filter #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int TAPS   = 16,
    parameter int SHIFT  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    fir_stream_filter_if.slave       stream,
    input  logic                     bypass,
    input  logic                     coef_we,
    input  logic [$clog2(TAPS)-1:0]  coef_addr,
    input  logic [COEF_W-1:0]        coef_data,
    output logic                     overrun,
    input  logic                     overrun_clr
);
    localparam int AW     = $clog2(TAPS);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = PROD_W + AW;

    localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t                    state_reg, state_next;
    logic [AW-1:0]             tap_reg;
    logic signed [ACC_W-1:0]   acc_reg;
    logic signed [DATA_W-1:0]  x_reg [TAPS];
    logic signed [COEF_W-1:0]  h_reg [TAPS];
    logic                      bypass_reg;
    logic                      out_valid_reg;
    logic [DATA_W-1:0]         out_data_reg;
    logic                      overrun_reg;

    logic                      idle;
    logic                      accept;
    logic                      coef_wr;
    logic                      drop;
    logic signed [DATA_W-1:0]  in_signed;
    logic signed [PROD_W-1:0]  prod;
    logic signed [ACC_W:0]     acc_ext;
    logic signed [ACC_W:0]     acc_rnd;
    logic signed [ACC_W:0]     shifted;
    logic signed [DATA_W-1:0]  sat_val;
    logic [DATA_W-1:0]         result;

    assign idle      = (state_reg == IDLE);
    assign accept    = idle && stream.in_valid;
    assign coef_wr   = idle && coef_we;
    assign drop      = !idle && (stream.in_valid || coef_we);
    assign in_signed = $signed({~stream.in_data[DATA_W-1], stream.in_data[DATA_W-2:0]});

    // Operands widened first so the product is formed at full signed width.
    assign prod = PROD_W'(x_reg[tap_reg]) * PROD_W'(h_reg[tap_reg]);

    assign acc_ext = {acc_reg[ACC_W-1], acc_reg};
`ifdef FIR_ROUND_EN
    localparam logic signed [ACC_W:0] RND = (SHIFT > 0) ? ((ACC_W+1)'(1) <<< (SHIFT - 1)) : '0;
    assign acc_rnd = acc_ext + RND;
`else
    assign acc_rnd = acc_ext;
`endif
    assign shifted = acc_rnd >>> SHIFT;

    always_comb begin
        sat_val = shifted[DATA_W-1:0];
        if (shifted > SAT_MAX) begin
            sat_val = SAT_MAX[DATA_W-1:0];
        end else if (shifted < SAT_MIN) begin
            sat_val = SAT_MIN[DATA_W-1:0];
        end
    end

    assign result = {~sat_val[DATA_W-1], sat_val[DATA_W-2:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Bypassed samples still pass through OUT so the block stays busy for one cycle.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = bypass ? OUT : MAC;
                end
            end
            MAC: begin
                if (tap_reg == AW'(TAPS - 1)) begin
                    state_next = OUT;
                end
            end
            OUT:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    generate
        for (genvar gi = 0; gi < TAPS; gi++) begin : g_taps
            if (gi == 0) begin : g_head
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        x_reg[gi] <= '0;
                    end else if (accept) begin
                        x_reg[gi] <= in_signed;
                    end
                end
            end else begin : g_body
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        x_reg[gi] <= '0;
                    end else if (accept) begin
                        x_reg[gi] <= x_reg[gi-1];
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    h_reg[gi] <= COEF_W'(1);
                end else if (coef_wr && (coef_addr == AW'(gi))) begin
                    h_reg[gi] <= coef_data;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tap_reg       <= '0;
            acc_reg       <= '0;
            bypass_reg    <= 1'b0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= {1'b1, {(DATA_W-1){1'b0}}};
            overrun_reg   <= 1'b0;
        end else begin
            out_valid_reg <= 1'b0;
            // A new drop wins over a simultaneous clear.
            if (drop) begin
                overrun_reg <= 1'b1;
            end else if (overrun_clr) begin
                overrun_reg <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        acc_reg    <= '0;
                        tap_reg    <= '0;
                        bypass_reg <= bypass;
                        if (bypass) begin
                            out_data_reg  <= stream.in_data;
                            out_valid_reg <= 1'b1;
                        end
                    end
                end
                MAC: begin
                    acc_reg <= acc_reg + ACC_W'(prod);
                    tap_reg <= tap_reg + AW'(1);
                end
                OUT: begin
                    if (!bypass_reg) begin
                        out_data_reg  <= result;
                        out_valid_reg <= 1'b1;
                    end
                end
                default: begin
                    tap_reg <= '0;
                end
            endcase
        end
    end

    assign stream.in_ready  = idle;
    assign stream.out_valid = out_valid_reg;
    assign stream.out_data  = out_data_reg;
    assign overrun          = overrun_reg;
endmodule

// File: tb/tb_fir_stream_filter.sv
// Scoreboard bench for fir_stream_filter: stimulus pushes expected results and their cycle,
// an independent monitor pops and compares each out_valid.
module tb_fir_stream_filter;
    localparam int DATA_W = 8;
    localparam int COEF_W = 8;
    localparam int TAPS   = 16;
    localparam int SHIFT  = 4;
    localparam int AW     = 4;
    localparam int FILT_LAT = TAPS + 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              bypass = 1'b0;
    logic              coef_we = 1'b0;
    logic [AW-1:0]     coef_addr = '0;
    logic [COEF_W-1:0] coef_data = '0;
    logic              overrun;
    logic              overrun_clr = 1'b0;

    fir_stream_filter_if #(.DATA_W(DATA_W)) bus ();

    fir_stream_filter #(
        .DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .SHIFT(SHIFT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stream     (bus.slave),
        .bypass     (bypass),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_data  (coef_data),
        .overrun    (overrun),
        .overrun_clr(overrun_clr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [7:0] data;
        int         when;
    } exp_t;
    exp_t sb[$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Monitor: every out_valid must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_out: got data %h at cycle %0d, required no output",
                         bus.out_data, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                $display("[TB] result %h at cycle %0d (expect %h at %0d)",
                         bus.out_data, cyc, e.data, e.when);
                check("out_data", 32'(bus.out_data), 32'(e.data));
                check("out_latency", 32'(cyc), 32'(e.when));
            end
        end
    end

    task automatic send(input logic [7:0] d, input bit byp, input logic [7:0] exp_d);
        @(negedge clk);
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        bypass       = byp;
        sb.push_back('{data: exp_d, when: cyc + (byp ? 1 : FILT_LAT)});
        @(negedge clk);
        bus.in_valid = 1'b0;
        bypass       = 1'b0;
        repeat (18) @(negedge clk);
    endtask

    task automatic write_coef(input logic [AW-1:0] a, input logic [COEF_W-1:0] d);
        @(negedge clk);
        coef_we   = 1'b1;
        coef_addr = a;
        coef_data = d;
        @(negedge clk);
        coef_we = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] r040;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;

        // Reset state
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_out_data", 32'(bus.out_data), 32'h80);
        check("rst_out_valid", 32'(bus.out_valid), 32'h0);
        check("rst_in_ready", 32'(bus.in_ready), 32'h1);
        check("rst_overrun", 32'(overrun), 32'h0);

        // Moving average ramp: n samples of +64 -> 4n above midscale
        for (int n = 1; n <= 16; n++) begin
            send(8'hC0, 1'b0, 8'(8'h80 + 4 * n));
        end

        // Single small sample: rounding decides between 0x80 and 0x81
        do_reset();
        check("rst_after_run_out_data", 32'(bus.out_data), 32'h80);
`ifdef FIR_ROUND_EN
        r040 = 8'h81;
`else
        r040 = 8'h80;
`endif
        send(8'h88, 1'b0, r040);

        // Saturation both ways with h = 0x7F
        do_reset();
        for (int k = 0; k < TAPS; k++) write_coef(AW'(k), 8'h7F);
        for (int k = 0; k < 4; k++) send(8'hFF, 1'b0, 8'hFF);
        for (int k = 0; k < 3; k++) send(8'h00, 1'b0, 8'hFF);
        send(8'h00, 1'b0, 8'h60);
        for (int k = 0; k < 4; k++) send(8'h00, 1'b0, 8'h00);

        // Two-cycle in_valid: second sample dropped, overrun set, then cleared
        do_reset();
        @(negedge clk);
        bus.in_data  = 8'hC0;
        bus.in_valid = 1'b1;
        sb.push_back('{data: 8'h84, when: cyc + FILT_LAT});
        @(negedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("overrun_set", 32'(overrun), 32'h1);
        check("in_ready_busy", 32'(bus.in_ready), 32'h0);
        repeat (20) @(negedge clk);
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        check("overrun_cleared", 32'(overrun), 32'h0);
        send(8'hC0, 1'b0, 8'h88);

        // Busy coefficient write is ignored; simultaneous clear loses to the new drop
        @(negedge clk);
        bus.in_data  = 8'hC0;
        bus.in_valid = 1'b1;
        sb.push_back('{data: 8'h8C, when: cyc + FILT_LAT});
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        coef_we     = 1'b1;
        coef_addr   = '0;
        coef_data   = 8'h10;
        overrun_clr = 1'b1;
        @(negedge clk);
        coef_we     = 1'b0;
        overrun_clr = 1'b0;
        check("overrun_clr_vs_drop", 32'(overrun), 32'h1);
        repeat (20) @(negedge clk);
        send(8'hC0, 1'b0, 8'h90);

        // Sample and coefficient write together in IDLE: MAC uses new h[0]
        do_reset();
        @(negedge clk);
        bus.in_data  = 8'hC0;
        bus.in_valid = 1'b1;
        coef_we      = 1'b1;
        coef_addr    = '0;
        coef_data    = 8'h10;
        sb.push_back('{data: 8'hC0, when: cyc + FILT_LAT});
        @(negedge clk);
        bus.in_valid = 1'b0;
        coef_we      = 1'b0;
        repeat (20) @(negedge clk);
        check("overrun_idle_write", 32'(overrun), 32'h0);

        // Bypass passes raw sample after one cycle and still feeds the delay line
        do_reset();
        send(8'h37, 1'b1, 8'h37);
        check("in_ready_after_bypass", 32'(bus.in_ready), 32'h1);
        send(8'hC0, 1'b0, 8'h7F);

        // Reset mid-MAC aborts with no result and clears the delay line
        @(negedge clk);
        bus.in_data  = 8'hC0;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_in_ready", 32'(bus.in_ready), 32'h1);
        check("abort_out_data", 32'(bus.out_data), 32'h80);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        send(8'hC0, 1'b0, 8'h84);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
